viterbi_traceback: RTL and testbench

Survivor-memory and traceback stage of the rate-1/2, K=3 (4-state) hard-decision Viterbi decoder. It sits directly downstream of the add-compare-select unit. Each cycle it stores that unit's four per-state predecessor decisions. After a full frame it traces back from the selected end state and emits the decoded information bits in forward time order over a valid/ready stream.

---
 rtl/viterbi_pkg.sv | 28 ++
 rtl/viterbi_surv_mem.sv | 37 +++
 rtl/viterbi_traceback.sv | 158 +++++++++++++++
 tb/tb_viterbi_traceback.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=3 hard-decision Viterbi traceback stage.
package viterbi_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_00 = 2'b00;
  localparam logic [ST_W-1:0] ST_10 = 2'b10;
  localparam logic [ST_W-1:0] ST_01 = 2'b01;
  localparam logic [ST_W-1:0] ST_11 = 2'b11;

  localparam int unsigned DEF_FRAME_LEN = 8;

  typedef enum logic [1:0] {FILL, TRACE, OUT} tb_state_t;

  // Survivor rows are packed {p11, p01, p10, p00}, low field first.
  function automatic logic [ST_W-1:0] surv_field(input logic [4*ST_W-1:0] row,
                                                 input logic [ST_W-1:0]   st);
    logic [ST_W-1:0] field;
    case (st)
      ST_00:   field = row[1:0];
      ST_10:   field = row[3:2];
      ST_01:   field = row[5:4];
      default: field = row[7:6];
    endcase
    return field;
  endfunction

endpackage

// File: rtl/viterbi_surv_mem.sv
// Survivor memory: FRAME_LEN rows of four 2-bit predecessor decisions,
// one registered write port and one combinational field-select read port.
module viterbi_surv_mem
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [4*ST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  input  logic [ST_W-1:0]   rstate,
  output logic [ST_W-1:0]   rfield
);

  logic [4*ST_W-1:0] mem_q [FRAME_LEN];
  logic [4*ST_W-1:0] mem_d [FRAME_LEN];
  logic [4*ST_W-1:0] rrow;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // No reset: every row is rewritten before it is read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rrow   = mem_q[raddr];
  assign rfield = surv_field(rrow, rstate);

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi survivor storage, traceback and in-order bit output stream.
// Define VITERBI_TB_TAIL_ZERO_EN to force the traceback start state to 00.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_tb,
  input  logic [ST_W-1:0] prev_st_00,
  input  logic [ST_W-1:0] prev_st_10,
  input  logic [ST_W-1:0] prev_st_01,
  input  logic [ST_W-1:0] prev_st_11,
  input  logic [ST_W-1:0] slt_node,
  output logic            dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            busy,
  output logic            frame_done,
  output logic            overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  tb_state_t              state_q, state_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;
  logic [ST_W-1:0]        cur_q, cur_d;
  logic [FRAME_LEN-1:0]   bitbuf_q, bitbuf_d;
  logic                   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;

  logic                   mem_we;
  logic [ST_W-1:0]        surv_pred;
  logic [ST_W-1:0]        start_st;

`ifdef VITERBI_TB_TAIL_ZERO_EN
  logic unused_slt;
  assign unused_slt = ^slt_node;
  assign start_st   = ST_00;
`else
  assign start_st   = slt_node;
`endif

  assign mem_we = en_tb && (state_q == FILL);

  viterbi_surv_mem #(
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_surv_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (wr_idx_q),
    .wdata  ({prev_st_11, prev_st_01, prev_st_10, prev_st_00}),
    .raddr  (rd_idx_q),
    .rstate (cur_q),
    .rfield (surv_pred)
  );

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    out_idx_d    = out_idx_q;
    cur_d        = cur_q;
    bitbuf_d     = bitbuf_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    // Steps arriving mid-traceback or mid-output are dropped.
    if (en_tb && (state_q != FILL)) begin
      overflow_d = 1'b1;
    end

    unique case (state_q)
      FILL: begin
        if (en_tb) begin
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            rd_idx_d = LAST_IDX;
            cur_d    = start_st;
            state_d  = TRACE;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      TRACE: begin
        bitbuf_d[rd_idx_q] = cur_q[1];
        cur_d              = surv_pred;
        if (rd_idx_q == '0) begin
          // Bit 0 is not in bitbuf_q yet, so present it straight from cur.
          state_d      = OUT;
          out_idx_d    = '0;
          dout_d       = cur_q[1];
          dout_valid_d = 1'b1;
        end else begin
          rd_idx_d = rd_idx_q - IDX_W'(1);
        end
      end
      OUT: begin
        if (dout_valid_q && dout_ready) begin
          if (out_idx_q == LAST_IDX) begin
            state_d      = FILL;
            out_idx_d    = '0;
            dout_d       = 1'b0;
            dout_valid_d = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            out_idx_d = out_idx_q + IDX_W'(1);
            dout_d    = bitbuf_q[out_idx_q + IDX_W'(1)];
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      out_idx_q    <= '0;
      cur_q        <= ST_00;
      bitbuf_q     <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      out_idx_q    <= out_idx_d;
      cur_q        <= cur_d;
      bitbuf_q     <= bitbuf_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = (state_q != FILL);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Randomized self-checking bench for viterbi_traceback (FRAME_LEN 8 and 4 instances).
module tb_viterbi_traceback;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, ready, sel4;
  logic [1:0] p00, p10, p01, p11, slt;

  logic d8, v8, b8, fd8, ov8;
  logic d4, v4, b4, fd4, ov4;
  logic dout, dout_valid, busy, frame_done, overflow;
  logic en8, en4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  logic [1:0] pred [8][4];
  bit         exp_bits [8];
  bit         ovf_exp8, ovf_exp4;

  always #5 clk = ~clk;

  assign en8        = en & ~sel4;
  assign en4        = en & sel4;
  assign dout       = sel4 ? d4  : d8;
  assign dout_valid = sel4 ? v4  : v8;
  assign busy       = sel4 ? b4  : b8;
  assign frame_done = sel4 ? fd4 : fd8;
  assign overflow   = sel4 ? ov4 : ov8;

  viterbi_traceback #(.FRAME_LEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .en_tb(en8),
    .prev_st_00(p00), .prev_st_10(p10), .prev_st_01(p01), .prev_st_11(p11),
    .slt_node(slt), .dout(d8), .dout_valid(v8), .dout_ready(ready),
    .busy(b8), .frame_done(fd8), .overflow(ov8)
  );

  viterbi_traceback #(.FRAME_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .en_tb(en4),
    .prev_st_00(p00), .prev_st_10(p10), .prev_st_01(p01), .prev_st_11(p11),
    .slt_node(slt), .dout(d4), .dout_valid(v4), .dout_ready(ready),
    .busy(b4), .frame_done(fd4), .overflow(ov4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Walk the survivor table backwards from the end state; bit at step t is s[1].
  function automatic void model(input int n, input logic [1:0] end_st);
    logic [1:0] s;
    s = end_st;
`ifdef VITERBI_TB_TAIL_ZERO_EN
    s = 2'b00;
`endif
    for (int t = n - 1; t >= 0; t--) begin
      exp_bits[t] = s[1];
      s = pred[t][s];
    end
  endfunction

  task automatic load(input int n, input logic [1:0] end_st);
    for (int t = 0; t < n; t++) begin
      en  = 1'b1;
      p00 = pred[t][0];
      p10 = pred[t][2];
      p01 = pred[t][1];
      p11 = pred[t][3];
      slt = (t == n - 1) ? end_st : 2'($urandom);
      tick;
    end
    en = 1'b0;
  endtask

  task automatic run_frame(input bit l4, input bit zero, input bit directed, input int stall_at,
                           input int stall_len, input bit ovf_pulse, input bit timing);
    int         n, t_last, idx, guard, stalled;
    logic [1:0] end_st;
    bit         ovf_e;
    n    = l4 ? 4 : 8;
    sel4 = l4;
    for (int t = 0; t < n; t++)
      for (int s = 0; s < 4; s++) pred[t][s] = zero ? 2'b00 : 2'($urandom);
    end_st = zero ? 2'b00 : 2'($urandom);
    if (directed) begin
      pred[3][2] = 2'b01;
      pred[2][1] = 2'b10;
      pred[1][2] = 2'b00;
      end_st     = 2'b10;
    end
    model(n, end_st);
    load(n, end_st);
    t_last = cyc - 1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", busy); end
    if (ovf_pulse) begin
      en  = 1'b1;
      p00 = ~pred[0][0]; p10 = ~pred[0][2]; p01 = ~pred[0][1]; p11 = ~pred[0][3];
      tick;
      en = 1'b0;
      if (l4) ovf_exp4 = 1'b1; else ovf_exp8 = 1'b1;
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b want 1", overflow); end
    end
    guard = 0;
    while (dout_valid !== 1'b1 && guard < 40) begin tick; guard++; end
    n_checks++;
    if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL valid_timeout: got %b want 1", dout_valid); end
    if (timing) begin
      n_checks++;
      if (cyc != t_last + n + 1)
        begin n_fail++; $display("FAIL valid_latency: got T+%0d want T+%0d", cyc - t_last, n + 1); end
    end
    idx = 0; guard = 0; stalled = 0;
    while (idx < n && guard < 60) begin
      if (idx == stall_at && stalled < stall_len) begin ready = 1'b0; stalled++; end
      else ready = 1'b1;
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== exp_bits[idx] || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL out_bit[%0d]: got dout=%b valid=%b fd=%b want dout=%b valid=1 fd=0",
                 idx, dout, dout_valid, frame_done, exp_bits[idx]);
      end
      if (ready) idx++;
      tick;
      guard++;
    end
    ready = 1'b1;
    ovf_e = l4 ? ovf_exp4 : ovf_exp8;
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0 || overflow !== ovf_e) begin
      n_fail++;
      $display("FAIL frame_end: got fd=%b busy=%b valid=%b ovf=%b want fd=1 busy=0 valid=0 ovf=%b",
               frame_done, busy, dout_valid, overflow, ovf_e);
    end
    if (timing && stall_len == 0 && !ovf_pulse) begin
      n_checks++;
      if (cyc != t_last + 2 * n + 1)
        begin n_fail++; $display("FAIL done_latency: got T+%0d want T+%0d", cyc - t_last, 2*n + 1); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; ready = 1'b1; sel4 = 1'b0;
    p00 = '0; p10 = '0; p01 = '0; p11 = '0; slt = '0;
    tick; tick;
    rst = 1'b0;
    ovf_exp8 = 1'b0; ovf_exp4 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sel4 = k[0];
      n_checks++;
      if ({dout, dout_valid, busy, frame_done, overflow} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %b want 00000", k,
                 {dout, dout_valid, busy, frame_done, overflow});
      end
    end
    sel4 = 1'b0;
  endtask

  task automatic test_all_zero;
    run_frame(1'b0, 1'b1, 1'b0, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_l4_directed;
    run_frame(1'b1, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stall;
    run_frame(1'b0, 1'b0, 1'b0, 3, 3, 1'b0, 1'b1);
  endtask

  task automatic test_overflow;
    run_frame(1'b0, 1'b0, 1'b0, -1, 0, 1'b1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0, 1, 2, 1'b1, 1'b1);
  endtask

  task automatic test_reset_in_out;
    int guard;
    sel4 = 1'b0;
    // Partial frame that must be discarded.
    for (int t = 0; t < 8; t++)
      for (int s = 0; s < 4; s++) pred[t][s] = 2'($urandom);
    load(3, 2'b11);
    rst = 1'b1; tick; rst = 1'b0;
    ovf_exp8 = 1'b0; ovf_exp4 = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);
    for (int t = 0; t < 8; t++)
      for (int s = 0; s < 4; s++) pred[t][s] = 2'($urandom);
    model(8, 2'b01);
    load(8, 2'b01);
    guard = 0;
    while (dout_valid !== 1'b1 && guard < 40) begin tick; guard++; end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== exp_bits[k])
        begin n_fail++; $display("FAIL rst_pre_bit[%0d]: got %b/%b want %b/1", k, dout,
                                 dout_valid, exp_bits[k]); end
      tick;
    end
    rst = 1'b1; tick; rst = 1'b0;
    n_checks++;
    if ({dout, dout_valid, busy, frame_done, overflow} !== 5'b0)
      begin n_fail++; $display("FAIL rst_in_out: got %b want 00000",
                               {dout, dout_valid, busy, frame_done, overflow}); end
    run_frame(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 5; f++) run_frame(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++) run_frame(1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++)
      run_frame(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(1, 4)),
                1'b0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_all_zero;
    test_l4_directed;
    test_stall;
    test_overflow;
    test_reset_in_out;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
